uart_rx_frame_parser: RTL

- Consumes bytes from the UART receive FIFO through its rd/empty/rd_data interface and parses framed messages: SOF, LEN, payload, checksum.
- Delivers payload bytes on a valid/ready byte stream and reports per-frame status pulses.
- Sits directly downstream of the UART receive path, between the RX FIFO and the command/application logic.

---
 rtl/uart_rx_frame_parser_if.sv | 26 ++
 rtl/uart_rx_frame_parser.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_parser_if.sv
// Bundle of the RX FIFO read port, the payload byte stream and the frame status outputs.
// The parser uses the master modport; the FIFO and consumer side uses the slave modport.
interface uart_rx_frame_parser_if #(
  parameter int dbit = 8
);
  logic            rx_empty;
  logic [dbit-1:0] rx_data;
  logic            rx_rd;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            frame_ok;
  logic            frame_err;
  logic [1:0]      err_code;

  modport master (
    input  rx_empty, rx_data, out_ready,
    output rx_rd, out_data, out_valid, out_last, frame_ok, frame_err, err_code
  );

  modport slave (
    output rx_empty, rx_data, out_ready,
    input  rx_rd, out_data, out_valid, out_last, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Parses SOF/LEN/payload/checksum frames from the UART RX FIFO and streams the payload out,
// reporting each frame as a one-cycle frame_ok or frame_err pulse.
module uart_rx_frame_parser #(
  parameter int         dbit    = 8,
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = 8'hAA,
  parameter int         TIMEOUT = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_frame_parser_if.master bus
);

  localparam int              IDLE_W       = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [7:0]      MAX_LEN_B    = 8'(MAX_LEN);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [7:0]        sum, sum_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic [7:0]        out_data_q, out_data_nxt;
  logic              out_valid_q, out_valid_nxt;
  logic              out_last_q, out_last_nxt;
  logic              frame_ok_q, frame_ok_nxt;
  logic              frame_err_q, frame_err_nxt;
  logic [1:0]        err_code_q, err_code_nxt;
  logic              pop;
  logic              avail;
  logic [7:0]        rx_byte;

  // Popping is suppressed during reset so no FIFO byte is lost while the parser clears.
  assign avail   = rst & ~bus.rx_empty;
  assign rx_byte = bus.rx_data[7:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= HUNT;
      cnt         <= '0;
      sum         <= '0;
      idle_cnt    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sum         <= sum_nxt;
      idle_cnt    <= idle_nxt;
      out_data_q  <= out_data_nxt;
      out_valid_q <= out_valid_nxt;
      out_last_q  <= out_last_nxt;
      frame_ok_q  <= frame_ok_nxt;
      frame_err_q <= frame_err_nxt;
      err_code_q  <= err_code_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sum_nxt       = sum;
    idle_nxt      = idle_cnt;
    out_data_nxt  = out_data_q;
    out_valid_nxt = out_valid_q;
    out_last_nxt  = out_last_q;
    frame_ok_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    err_code_nxt  = err_code_q;
    pop           = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_nxt = 1'b0;
      out_last_nxt  = 1'b0;
    end

    case (state)
      HUNT: begin
        pop      = avail;
        idle_nxt = '0;
        if (pop && rx_byte == SOF) state_nxt = LEN;
      end
      LEN: begin
        pop = avail;
        if (pop) begin
          sum_nxt = rx_byte;
          if (rx_byte > MAX_LEN_B) begin
            frame_err_nxt = 1'b1;
            err_code_nxt  = 2'b10;
            state_nxt     = HUNT;
          end else if (rx_byte == 8'd0) begin
            state_nxt = CHK;
          end else begin
            cnt_nxt   = rx_byte;
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        pop = avail & (~out_valid_q | bus.out_ready);
        if (pop) begin
          out_data_nxt  = rx_byte;
          out_valid_nxt = 1'b1;
          out_last_nxt  = (cnt == 8'd1);
          sum_nxt       = sum + rx_byte;
          cnt_nxt       = cnt - 8'd1;
          if (cnt == 8'd1) state_nxt = CHK;
        end
      end
      CHK: begin
        pop = avail;
        if (pop) begin
          if (rx_byte == sum) begin
            frame_ok_nxt = 1'b1;
            err_code_nxt = 2'b00;
          end else begin
            frame_err_nxt = 1'b1;
            err_code_nxt  = 2'b01;
          end
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase

    // Mid-frame starvation watchdog; a pending output byte is left untouched.
    if (state != HUNT) begin
      if (pop) begin
        idle_nxt = '0;
      end else if (bus.rx_empty) begin
        if (idle_cnt == TIMEOUT_LAST) begin
          frame_err_nxt = 1'b1;
          err_code_nxt  = 2'b11;
          state_nxt     = HUNT;
          idle_nxt      = '0;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.rx_rd     = pop;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;

endmodule
